// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle core: opcodes, FSM states, ALU selects
// and instruction field offsets measured from the top of the immediate field.
package cpu_pkg;

    localparam int OPC_W  = 4;
    localparam int REG_FW = 4;

    // Field offsets are relative to DATA_W, because the immediate sits in the low DATA_W bits.
    localparam int RB_OFS = 0;
    localparam int RA_OFS = 4;
    localparam int RD_OFS = 8;
    localparam int OP_OFS = 12;

    localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OPC_W-1:0] OP_ADD  = 4'h1;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'h2;
    localparam logic [OPC_W-1:0] OP_AND  = 4'h3;
    localparam logic [OPC_W-1:0] OP_OR   = 4'h4;
    localparam logic [OPC_W-1:0] OP_XOR  = 4'h5;
    localparam logic [OPC_W-1:0] OP_SHL  = 4'h6;
    localparam logic [OPC_W-1:0] OP_SHR  = 4'h7;
    localparam logic [OPC_W-1:0] OP_ADDI = 4'h8;
    localparam logic [OPC_W-1:0] OP_LDI  = 4'h9;
    localparam logic [OPC_W-1:0] OP_OUT  = 4'hA;
    localparam logic [OPC_W-1:0] OP_JMP  = 4'hB;
    localparam logic [OPC_W-1:0] OP_BZ   = 4'hC;
    localparam logic [OPC_W-1:0] OP_BC   = 4'hD;
    localparam logic [OPC_W-1:0] OP_CMP  = 4'hE;
    localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXEC,
        ST_HALT
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SHL,
        ALU_SHR
    } alu_op_e;

    // Arithmetic/logic ops 1..8 and CMP are the only instructions that touch the flags.
    function automatic logic writes_flags(input logic [OPC_W-1:0] op);
        return ((op >= OP_ADD) && (op <= OP_ADDI)) || (op == OP_CMP);
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: result plus zero flag and a carry whose meaning depends on the op
// (carry-out, borrow, or the bit shifted out).
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_e           op,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              carry
);

    logic [DATA_W:0] wide;

    // The extra top bit of 'wide' holds carry-out for ADD and borrow for SUB.
    always_comb begin
        wide   = '0;
        result = '0;
        carry  = 1'b0;
        case (op)
            ALU_ADD: begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[DATA_W-1:0];
                carry  = wide[DATA_W];
            end
            ALU_SUB: begin
                wide   = {1'b0, a} - {1'b0, b};
                result = wide[DATA_W-1:0];
                carry  = wide[DATA_W];
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SHL: begin
                result = {a[DATA_W-2:0], 1'b0};
                carry  = a[DATA_W-1];
            end
            ALU_SHR: begin
                result = {1'b0, a[DATA_W-1:1]};
                carry  = a[0];
            end
            default: ;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle core: FETCH/EXEC/HALT sequencer with a req/ack instruction fetch,
// register file with hardwired-zero r0, flags, branches and a latched output port.
module cpu_core
    import cpu_pkg::*;
#(
    parameter  int DATA_W    = 8,
    parameter  int REG_COUNT = 16,
    parameter  int ADDR_W    = 8,
    localparam int INSTR_W   = 16 + DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    output logic               halted,
    output logic               flag_z,
    output logic               flag_c
);

    localparam int REG_W = $clog2(REG_COUNT);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic                req_q, req_d;
    logic                z_q, z_d;
    logic                c_q, c_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   regs_q [REG_COUNT];

    logic                fetch_active;
    logic                wr_en;
    logic [DATA_W-1:0]   wr_data;

    logic [OPC_W-1:0]    opcode;
    logic [REG_W-1:0]    rd_idx, ra_idx, rb_idx;
    logic [DATA_W-1:0]   imm;
    logic [DATA_W-1:0]   ra_val, rb_val;

    alu_op_e             alu_op;
    logic [DATA_W-1:0]   alu_b;
    logic [DATA_W-1:0]   alu_result;
    logic                alu_zero;
    logic                alu_carry;

    assign opcode = instr_q[DATA_W+OP_OFS +: OPC_W];
    assign rd_idx = instr_q[DATA_W+RD_OFS +: REG_W];
    assign ra_idx = instr_q[DATA_W+RA_OFS +: REG_W];
    assign rb_idx = instr_q[DATA_W+RB_OFS +: REG_W];
    assign imm    = instr_q[DATA_W-1:0];

    // r0 is never written, so a plain array read already returns zero for it.
    assign ra_val = regs_q[ra_idx];
    assign rb_val = regs_q[rb_idx];

    // A request, once raised, is held by req_q until acked, independent of run.
    assign fetch_active = (state_q == ST_FETCH) && (run || req_q);
    assign imem_req     = rst && fetch_active;
    assign imem_addr    = pc_q;

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign halted    = (state_q == ST_HALT);
    assign flag_z    = z_q;
    assign flag_c    = c_q;

    always_comb begin
        alu_op = ALU_ADD;
        alu_b  = rb_val;
        case (opcode)
            OP_SUB, OP_CMP: alu_op = ALU_SUB;
            OP_AND:         alu_op = ALU_AND;
            OP_OR:          alu_op = ALU_OR;
            OP_XOR:         alu_op = ALU_XOR;
            OP_SHL:         alu_op = ALU_SHL;
            OP_SHR:         alu_op = ALU_SHR;
            OP_ADDI:        alu_b  = imm;
            default: ;
        endcase
    end

    cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a      (ra_val),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result),
        .zero   (alu_zero),
        .carry  (alu_carry)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        req_d       = req_q;
        z_d         = z_q;
        c_d         = c_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        wr_en       = 1'b0;
        wr_data     = alu_result;
        unique case (state_q)
            ST_FETCH: begin
                if (fetch_active) begin
                    if (imem_ack) begin
                        instr_d = imem_data;
                        req_d   = 1'b0;
                        state_d = ST_EXEC;
                    end else begin
                        req_d = 1'b1;
                    end
                end
            end
            ST_EXEC: begin
                pc_d    = pc_q + 1'b1;
                state_d = ST_FETCH;
                if (writes_flags(opcode)) begin
                    z_d = alu_zero;
                    c_d = alu_carry;
                end
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_ADDI:
                        wr_en = (rd_idx != '0);
                    OP_LDI: begin
                        wr_en   = (rd_idx != '0);
                        wr_data = imm;
                    end
                    OP_OUT: begin
                        out_data_d  = ra_val;
                        out_valid_d = 1'b1;
                    end
                    OP_JMP: pc_d = imm[ADDR_W-1:0];
                    OP_BZ:  if (z_q) pc_d = imm[ADDR_W-1:0];
                    OP_BC:  if (c_q) pc_d = imm[ADDR_W-1:0];
                    OP_HALT: state_d = ST_HALT;
                    default: ;
                endcase
            end
            ST_HALT: ;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_FETCH;
            pc_q        <= '0;
            instr_q     <= '0;
            req_q       <= 1'b0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            req_q       <= req_d;
            z_q         <= z_d;
            c_q         <= c_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[rd_idx] <= wr_data;
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// Self-checking bench for cpu_core: directed scenarios plus random programs
// compared against an instruction-level interpreter.
module tb_cpu_core;

   logic        clk;
   logic        rst;
   logic        run;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ack;
   logic [23:0] imem_data;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        halted;
   logic        flag_z;
   logic        flag_c;

   logic [23:0] mem [256];
   int          waitCfg;
   int          waitCnt;
   bit          ackNoise;
   int          fetchLog[$];
   int          outLog[$];
   int          expTrace[$];
   int          expOut[$];
   logic        expZ;
   logic        expC;
   int          checks;
   int          errors;

   cpu_core dut (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .imem_req  (imem_req),
      .imem_addr (imem_addr),
      .imem_ack  (imem_ack),
      .imem_data (imem_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .halted    (halted),
      .flag_z    (flag_z),
      .flag_c    (flag_c)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory with a programmable number of wait states; optionally
   // raises stray acks with junk data while no request is pending.
   always @(negedge clk) begin
      if (imem_req) begin
         if (waitCnt >= waitCfg) begin
            imem_ack  = 1'b1;
            imem_data = mem[imem_addr];
            waitCnt   = 0;
            fetchLog.push_back(int'(imem_addr));
         end else begin
            imem_ack  = 1'b0;
            imem_data = 24'($urandom);
            waitCnt++;
         end
      end else begin
         waitCnt = 0;
         if (ackNoise && ($urandom_range(0, 2) == 0)) begin
            imem_ack  = 1'b1;
            imem_data = 24'($urandom);
         end else begin
            imem_ack = 1'b0;
         end
      end
   end

   // Records every value presented on the output port.
   always @(negedge clk) begin
      if (rst && out_valid) outLog.push_back(int'(out_data));
   end

   function automatic logic [23:0] enc(input int op, input int rd, input int ra,
                                       input int rb, input int imm);
      logic [23:0] w;
      w = {op[3:0], rd[3:0], ra[3:0], rb[3:0], imm[7:0]};
      return w;
   endfunction

   task automatic fillHalt();
      for (int i = 0; i < 256; i++) mem[i] = enc(15, 0, 0, 0, 0);
   endtask

   // Puts the core into reset with run low, then releases it and clears the logs.
   task automatic applyReset();
      rst      = 1'b0;
      run      = 1'b0;
      waitCfg  = 0;
      ackNoise = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      fetchLog.delete();
      outLog.delete();
   endtask

   task automatic startRun();
      @(posedge clk);
      #2 run = 1'b1;
   endtask

   task automatic waitHalted(input int budget, output int n);
      n = 0;
      while (n < budget) begin
         @(negedge clk);
         n++;
         if (halted) break;
      end
   endtask

   // Instruction-level interpreter of the ISA: executes mem from address 0 until HALT.
   task automatic runModel();
      int r[16];
      int pc, npc, op, rd, ra, rb, imm, a, b, res;
      logic [23:0] w;
      bit wr, fl, c;
      expTrace.delete();
      expOut.delete();
      expZ = 1'b0;
      expC = 1'b0;
      for (int i = 0; i < 16; i++) r[i] = 0;
      pc = 0;
      for (int step = 0; step < 1000; step++) begin
         w   = mem[pc];
         expTrace.push_back(pc);
         op  = int'(w[23:20]);
         rd  = int'(w[19:16]);
         ra  = int'(w[15:12]);
         rb  = int'(w[11:8]);
         imm = int'(w[7:0]);
         a   = r[ra];
         b   = r[rb];
         npc = (pc + 1) % 256;
         wr  = 0;
         fl  = 0;
         c   = 0;
         res = 0;
         if (op == 15) break;
         case (op)
            1:  begin res = a + b;   c = (res > 255); wr = 1; fl = 1; end
            2:  begin res = a - b;   c = (a < b);     wr = 1; fl = 1; end
            3:  begin res = a & b;   wr = 1; fl = 1; end
            4:  begin res = a | b;   wr = 1; fl = 1; end
            5:  begin res = a ^ b;   wr = 1; fl = 1; end
            6:  begin res = a * 2;   c = (a >= 128);  wr = 1; fl = 1; end
            7:  begin res = a / 2;   c = (a % 2 == 1); wr = 1; fl = 1; end
            8:  begin res = a + imm; c = (res > 255); wr = 1; fl = 1; end
            9:  begin res = imm;     wr = 1; end
            10: expOut.push_back(a);
            11: npc = imm;
            12: if (expZ) npc = imm;
            13: if (expC) npc = imm;
            14: begin res = a - b;   c = (a < b);     fl = 1; end
            default: ;
         endcase
         res = ((res % 256) + 256) % 256;
         if (fl) begin
            expZ = (res == 0);
            expC = c;
         end
         if (wr && rd != 0) r[rd] = res;
         pc = npc;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      run = 1'b1;
      #1;
      checks++;
      if (imem_req !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_req_in_reset: got %b expected 0", imem_req);
      end
      applyReset();
      @(negedge clk);
      checks++;
      if ({imem_req, halted, out_valid, flag_z, flag_c} !== 5'b0) begin
         errors++;
         $display("[TB] FAIL reset_ctrl: got req/halt/ov/z/c=%b expected 00000",
                  {imem_req, halted, out_valid, flag_z, flag_c});
      end
      checks++;
      if (imem_addr !== 8'h00 || out_data !== 8'h00) begin
         errors++;
         $display("[TB] FAIL reset_data: got addr=%h out=%h expected 00/00", imem_addr, out_data);
      end
   endtask

   task automatic test_add_flags();
      int n;
      applyReset();
      fillHalt();
      mem[0] = enc(9, 1, 0, 0, 'hF0);
      mem[1] = enc(9, 2, 0, 0, 'h20);
      mem[2] = enc(1, 3, 1, 2, 0);
      mem[3] = enc(10, 0, 3, 0, 0);
      startRun();
      waitHalted(200, n);
      checks++;
      if (n !== 11) begin
         errors++;
         $display("[TB] FAIL add_cycles: got %0d cycles to halted, expected 11", n);
      end
      checks++;
      if (outLog.size() != 1 || outLog[0] != 'h10) begin
         errors++;
         $display("[TB] FAIL add_result: got %0d outputs first=%h expected 1 output 10",
                  outLog.size(), outLog[0]);
      end
      checks++;
      if (flag_c !== 1'b1 || flag_z !== 1'b0) begin
         errors++;
         $display("[TB] FAIL add_flags: got C=%b Z=%b expected C=1 Z=0", flag_c, flag_z);
      end
   endtask

   task automatic test_r0();
      int n;
      int pulses;
      applyReset();
      fillHalt();
      mem[0] = enc(9, 1, 0, 0, 'h77);
      mem[1] = enc(10, 0, 1, 0, 0);
      mem[2] = enc(9, 0, 0, 0, 'h55);
      mem[3] = enc(10, 0, 0, 0, 0);
      startRun();
      pulses = 0;
      for (n = 0; n < 40; n++) begin
         @(negedge clk);
         if (out_valid) pulses++;
      end
      checks++;
      if (pulses !== 2) begin
         errors++;
         $display("[TB] FAIL r0_pulses: got %0d out_valid cycles expected 2", pulses);
      end
      checks++;
      if (outLog.size() != 2 || outLog[0] != 'h77 || outLog[1] != 0) begin
         errors++;
         $display("[TB] FAIL r0_value: got %0d outputs last=%h expected 77 then 00",
                  outLog.size(), out_data);
      end
   endtask

   task automatic test_wait_states();
      int n;
      int reqCycles;
      bit addrBad;
      applyReset();
      fillHalt();
      mem[0] = enc(9, 1, 0, 0, 'h3C);
      mem[1] = enc(10, 0, 1, 0, 0);
      waitCfg   = 3;
      reqCycles = 0;
      addrBad   = 0;
      startRun();
      @(negedge clk);
      if (imem_req) reqCycles++;
      if (imem_addr !== 8'h00) addrBad = 1;
      @(posedge clk);
      #2 run = 1'b0;
      repeat (11) begin
         @(negedge clk);
         if (imem_req) begin
            reqCycles++;
            if (imem_addr !== 8'h00) addrBad = 1;
         end
      end
      checks++;
      if (reqCycles !== 4) begin
         errors++;
         $display("[TB] FAIL wait_req_len: got %0d request cycles expected 4", reqCycles);
      end
      checks++;
      if (addrBad !== 1'b0) begin
         errors++;
         $display("[TB] FAIL wait_addr_stable: got unstable address expected constant 00");
      end
      checks++;
      if (fetchLog.size() != 1 || imem_addr !== 8'h01) begin
         errors++;
         $display("[TB] FAIL wait_single_exec: got %0d fetches pc=%h expected 1 fetch pc=01",
                  fetchLog.size(), imem_addr);
      end
      startRun();
      waitHalted(200, n);
      checks++;
      if (outLog.size() != 1 || outLog[0] != 'h3C) begin
         errors++;
         $display("[TB] FAIL wait_result: got %0d outputs first=%h expected 3c",
                  outLog.size(), outLog[0]);
      end
   endtask

   task automatic test_branch();
      int n;
      applyReset();
      fillHalt();
      mem[0] = enc(14, 0, 1, 1, 0);
      mem[1] = enc(12, 0, 0, 0, 'h40);
      startRun();
      waitHalted(200, n);
      checks++;
      if (fetchLog.size() != 3 || fetchLog[2] != 'h40) begin
         errors++;
         $display("[TB] FAIL bz_taken: got %0d fetches third=%h expected 3 fetches third=40",
                  fetchLog.size(), fetchLog[2]);
      end
      applyReset();
      fillHalt();
      mem[0] = enc(9, 1, 0, 0, 1);
      mem[1] = enc(14, 0, 1, 2, 0);
      mem[2] = enc(12, 0, 0, 0, 'h40);
      startRun();
      waitHalted(200, n);
      checks++;
      if (fetchLog.size() != 4 || fetchLog[3] != 3) begin
         errors++;
         $display("[TB] FAIL bz_not_taken: got %0d fetches fourth=%h expected 4 fetches fourth=03",
                  fetchLog.size(), fetchLog[3]);
      end
   endtask

   task automatic test_wrap();
      int n;
      applyReset();
      fillHalt();
      mem[0]   = enc(11, 0, 0, 0, 'hFF);
      mem[255] = enc(0, 0, 0, 0, 0);
      startRun();
      n = 0;
      while (fetchLog.size() < 3 && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #2 run = 1'b0;
      checks++;
      if (fetchLog.size() < 3 || fetchLog[1] != 255 || fetchLog[2] != 0) begin
         errors++;
         $display("[TB] FAIL pc_wrap: got fetches %0d,%0d expected 255,0", fetchLog[1], fetchLog[2]);
      end
   endtask

   task automatic test_halt();
      int n;
      int reqSeen;
      applyReset();
      fillHalt();
      startRun();
      waitHalted(50, n);
      checks++;
      if (halted !== 1'b1 || n !== 3) begin
         errors++;
         $display("[TB] FAIL halt_entry: got halted=%b after %0d cycles expected 1 after 3", halted, n);
      end
      ackNoise = 1'b1;
      reqSeen  = 0;
      repeat (20) begin
         @(negedge clk);
         if (imem_req) reqSeen++;
      end
      checks++;
      if (reqSeen !== 0 || halted !== 1'b1) begin
         errors++;
         $display("[TB] FAIL halt_quiet: got %0d request cycles halted=%b expected 0 and 1",
                  reqSeen, halted);
      end
   endtask

   task automatic test_reset_mid_request();
      int n;
      applyReset();
      fillHalt();
      for (int i = 0; i < 10; i++) mem[i] = enc(0, 0, 0, 0, 0);
      startRun();
      n = 0;
      while (fetchLog.size() < 4 && n < 50) begin
         @(negedge clk);
         n++;
      end
      waitCfg = 20;
      repeat (4) @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 8'h04) begin
         errors++;
         $display("[TB] FAIL midreq_setup: got req=%b addr=%h expected 1/04", imem_req, imem_addr);
      end
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      checks++;
      if (imem_req !== 1'b0 || imem_addr !== 8'h00) begin
         errors++;
         $display("[TB] FAIL midreq_reset: got req=%b addr=%h expected 0/00", imem_req, imem_addr);
      end
      #5 rst = 1'b1;
   endtask

   task automatic test_random();
      int n;
      int bodyLen;
      int op;
      int firstBad;
      bodyLen = 24;
      for (int p = 0; p < 8; p++) begin
         fillHalt();
         for (int pc = 0; pc < bodyLen; pc++) begin
            op = $urandom_range(0, 14);
            if (op >= 11 && op <= 13)
               mem[pc] = enc(op, 0, 0, 0, $urandom_range(pc + 1, bodyLen));
            else
               mem[pc] = enc(op, $urandom_range(0, 15), $urandom_range(0, 15),
                             $urandom_range(0, 15), $urandom_range(0, 255));
         end
         for (int k = 1; k < 16; k++) mem[bodyLen + k - 1] = enc(10, 0, k, 0, 0);
         runModel();
         applyReset();
         waitCfg  = $urandom_range(0, 2);
         ackNoise = 1'b1;
         startRun();
         waitHalted(2000, n);
         checks++;
         if (halted !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rand%0d_halt: got halted=%b expected 1", p, halted);
         end
         firstBad = (fetchLog.size() != expTrace.size()) ? 0 : -1;
         for (int i = 0; i < fetchLog.size() && i < expTrace.size(); i++)
            if (firstBad < 0 && fetchLog[i] != expTrace[i]) firstBad = i;
         checks++;
         if (firstBad >= 0) begin
            errors++;
            $display("[TB] FAIL rand%0d_trace: got %0d fetches (%0d at index %0d) expected %0d (%0d)",
                     p, fetchLog.size(), fetchLog[firstBad], firstBad, expTrace.size(),
                     expTrace[firstBad]);
         end
         firstBad = (outLog.size() != expOut.size()) ? 0 : -1;
         for (int i = 0; i < outLog.size() && i < expOut.size(); i++)
            if (firstBad < 0 && outLog[i] != expOut[i]) firstBad = i;
         checks++;
         if (firstBad >= 0) begin
            errors++;
            $display("[TB] FAIL rand%0d_out: got %0d outputs (%h at index %0d) expected %0d (%h)",
                     p, outLog.size(), outLog[firstBad], firstBad, expOut.size(), expOut[firstBad]);
         end
         checks++;
         if (flag_z !== expZ || flag_c !== expC) begin
            errors++;
            $display("[TB] FAIL rand%0d_flags: got Z=%b C=%b expected Z=%b C=%b",
                     p, flag_z, flag_c, expZ, expC);
         end
      end
   endtask

   // Runs every scenario in order, then prints the summary.
   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1'b0;
      run       = 1'b0;
      imem_ack  = 1'b0;
      imem_data = '0;
      waitCfg   = 0;
      waitCnt   = 0;
      ackNoise  = 1'b0;
      fillHalt();
      test_reset();
      test_add_flags();
      test_r0();
      test_wait_states();
      test_branch();
      test_wrap();
      test_halt();
      test_reset_mid_request();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
